// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot allocator.
// GATE_TIMER_EN adds the GATE_HOLD state used by the entry barrier timer.
package parking_pkg;

    localparam int NUM_SLOTS = 15;
    localparam int IDX_W     = 4;

    typedef logic [IDX_W-1:0]     slot_idx_t;
    typedef logic [NUM_SLOTS-1:0] occ_vec_t;

    localparam slot_idx_t SLOTS_N = slot_idx_t'(NUM_SLOTS);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_SCAN,
        ENTRY_RESP,
        EXIT_RESP,
`ifdef GATE_TIMER_EN
        WAIT_REL,
        GATE_HOLD
`else
        WAIT_REL
`endif
    } alloc_state_t;

    // Out-of-range indices shift the one out, giving an empty mask.
    function automatic occ_vec_t slot_mask(slot_idx_t i);
        return occ_vec_t'(1) << i;
    endfunction

endpackage

// File: rtl/parking_slot_allocator_if.sv
// Gate-side request/response bundle of the parking slot allocator.
// Master is the gate sensor side, slave is the allocator.
interface parking_slot_allocator_if;
    import parking_pkg::*;

    logic      entry_req;
    logic      exit_req;
    slot_idx_t exit_slot;
    logic      entry_ack;
    logic      entry_nack;
    slot_idx_t entry_slot;
    logic      exit_ack;
    logic      exit_err;
    occ_vec_t  car_occ;
    slot_idx_t free_cnt;
    logic      gate_open;

    modport master (
        output entry_req,
        output exit_req,
        output exit_slot,
        input  entry_ack,
        input  entry_nack,
        input  entry_slot,
        input  exit_ack,
        input  exit_err,
        input  car_occ,
        input  free_cnt,
        input  gate_open
    );

    modport slave (
        input  entry_req,
        input  exit_req,
        input  exit_slot,
        output entry_ack,
        output entry_nack,
        output entry_slot,
        output exit_ack,
        output exit_err,
        output car_occ,
        output free_cnt,
        output gate_open
    );

endinterface

// File: rtl/slot_priority_enc.sv
// Lowest-free-slot finder over the occupancy vector.
// full_o is set when no slot is free; idx_o is then 0.
module slot_priority_enc
    import parking_pkg::*;
(
    input  occ_vec_t  occ_i,
    output logic      full_o,
    output slot_idx_t idx_o
);

    // Scan downwards so the lowest free index is the last written.
    always_comb begin
        full_o = 1'b1;
        idx_o  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_i[i]) begin
                full_o = 1'b0;
                idx_o  = slot_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/parking_slot_allocator.sv
// Entry/exit slot allocator owning car_occ and the free-slot count.
// Define GATE_TIMER_EN to drive gate_open for GATE_CYCLES after a grant.
module parking_slot_allocator
    import parking_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000
) (
    input logic               clk,
    input logic               rst,
    parking_slot_allocator_if.slave bus
);

    alloc_state_t state_q, state_d;
    occ_vec_t     occ_q, occ_d;
    slot_idx_t    free_q, free_d;
    slot_idx_t    slot_q, slot_d;
    slot_idx_t    idx_q, idx_d;
    logic         full_q, full_d;
    logic         srv_exit_q, srv_exit_d;
    logic         eack_q, eack_d;
    logic         enack_q, enack_d;
    logic         xack_q, xack_d;
    logic         xerr_q, xerr_d;

    logic         enc_full;
    slot_idx_t    enc_idx;
    logic         exit_hit;
    logic         srv_req;
    logic         gate_busy;
    logic         gate_last;

    slot_priority_enc u_enc (
        .occ_i  (occ_q),
        .full_o (enc_full),
        .idx_o  (enc_idx)
    );

    assign exit_hit = (bus.exit_slot < SLOTS_N)
                   && ((occ_q & slot_mask(bus.exit_slot)) != '0);
    assign srv_req  = srv_exit_q ? bus.exit_req : bus.entry_req;

`ifdef GATE_TIMER_EN
    localparam int GW = $clog2(GATE_CYCLES + 1);

    logic          gate_q;
    logic [GW-1:0] gcnt_q;

    // Window starts on the grant edge, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q <= 1'b0;
            gcnt_q <= '0;
        end else if (eack_d) begin
            gate_q <= 1'b1;
            gcnt_q <= GW'(GATE_CYCLES - 1);
        end else if (gate_q) begin
            if (gcnt_q == '0) begin
                gate_q <= 1'b0;
            end else begin
                gcnt_q <= gcnt_q - 1'b1;
            end
        end
    end

    assign gate_last     = gate_q && (gcnt_q == '0);
    assign gate_busy     = gate_q && !gate_last;
    assign bus.gate_open = gate_q;
`else
    logic unused_gate;

    assign unused_gate   = (GATE_CYCLES == 0);
    assign gate_last     = 1'b0;
    assign gate_busy     = 1'b0;
    assign bus.gate_open = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        free_d     = free_q;
        slot_d     = slot_q;
        idx_d      = idx_q;
        full_d     = full_q;
        srv_exit_d = srv_exit_q;
        eack_d     = 1'b0;
        enack_d    = 1'b0;
        xack_d     = 1'b0;
        xerr_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Exit first so a departure can make room.
                if (bus.exit_req) begin
                    srv_exit_d = 1'b1;
                    state_d    = EXIT_RESP;
                end else if (bus.entry_req) begin
                    srv_exit_d = 1'b0;
                    state_d    = ENTRY_SCAN;
                end
            end
            ENTRY_SCAN: begin
                full_d  = enc_full;
                idx_d   = enc_idx;
                state_d = ENTRY_RESP;
            end
            ENTRY_RESP: begin
                if (!full_q && free_q != '0) begin
                    occ_d  = occ_q | slot_mask(idx_q);
                    slot_d = idx_q;
                    free_d = free_q - 1'b1;
                    eack_d = 1'b1;
                end else begin
                    enack_d = 1'b1;
                end
                state_d = WAIT_REL;
            end
            EXIT_RESP: begin
                if (exit_hit) begin
                    occ_d  = occ_q & ~slot_mask(bus.exit_slot);
                    free_d = free_q + 1'b1;
                    xack_d = 1'b1;
                end else begin
                    xerr_d = 1'b1;
                end
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!srv_req) begin
`ifdef GATE_TIMER_EN
                    state_d = gate_busy ? GATE_HOLD : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef GATE_TIMER_EN
            GATE_HOLD: begin
                if (!gate_busy) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            occ_q      <= '0;
            free_q     <= SLOTS_N;
            slot_q     <= '0;
            idx_q      <= '0;
            full_q     <= 1'b0;
            srv_exit_q <= 1'b0;
            eack_q     <= 1'b0;
            enack_q    <= 1'b0;
            xack_q     <= 1'b0;
            xerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            free_q     <= free_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            full_q     <= full_d;
            srv_exit_q <= srv_exit_d;
            eack_q     <= eack_d;
            enack_q    <= enack_d;
            xack_q     <= xack_d;
            xerr_q     <= xerr_d;
        end
    end

    assign bus.entry_ack  = eack_q;
    assign bus.entry_nack = enack_q;
    assign bus.entry_slot = slot_q;
    assign bus.exit_ack   = xack_q;
    assign bus.exit_err   = xerr_q;
    assign bus.car_occ    = occ_q;
    assign bus.free_cnt   = free_q;

endmodule
